// File: rtl/rx_frame_parser.sv
// rx_frame_parser: strips preamble/SFD/FCS from a byte-wide RGMII receive
// stream and flags CRC, runt, oversize and rxEr errors on the last byte.
//
// Ports:
//   clkIn       125 MHz receive clock (only clock)
//   rstIn       asynchronous active-high reset
//   rxDvIn      receive data valid
//   rxErIn      receive error, qualified by rxDvIn
//   rxDataIn    received byte
//   dataOut     payload byte (preamble, SFD, FCS removed)
//   validOut    dataOut valid, single cycle, no backpressure
//   lastOut     final payload byte of the frame
//   fcsErrOut   CRC mismatch, meaningful with lastOut
//   frameErrOut runt/oversize/rxEr, meaningful with lastOut
//   goodCntOut  saturating count of good frames
//   badCntOut   saturating count of errored or dropped frames
module rx_frame_parser #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        rxDvIn,
  input  logic        rxErIn,
  input  logic [7:0]  rxDataIn,
  output logic [7:0]  dataOut,
  output logic        validOut,
  output logic        lastOut,
  output logic        fcsErrOut,
  output logic        frameErrOut,
  output logic [15:0] goodCntOut,
  output logic [15:0] badCntOut
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] DLY      = 11'd5;

  function automatic logic [31:0] crcByte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  state_t          state, stateNxt;
  logic [4:0][7:0] dl, dlNxt;
  logic [10:0]     lenCnt, lenNxt;
  logic [31:0]     crc, crcNxt;
  logic            erSeen, erNxt;
  // Cleared by reset; set once rxDvIn=0 is seen, so a frame already
  // in flight when reset drops is discarded without being counted.
  logic            armed, armedNxt;
  logic [7:0]      dataNxt;
  logic            validNxt, lastNxt;
  logic            fcsNxt, frameNxt;
  logic            goodInc, badInc;
  logic [15:0]     goodNxt, badNxt;

  always_comb begin
    stateNxt = state;
    dlNxt    = dl;
    lenNxt   = lenCnt;
    crcNxt   = crc;
    erNxt    = erSeen;
    armedNxt = armed | ~rxDvIn;
    dataNxt  = dataOut;
    validNxt = 1'b0;
    lastNxt  = 1'b0;
    fcsNxt   = 1'b0;
    frameNxt = 1'b0;
    goodInc  = 1'b0;
    badInc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxDvIn) begin
          if (!armed) begin
            stateNxt = DROP;
          end else if (rxDataIn == 8'h55) begin
            stateNxt = PREAMBLE;
          end else begin
            stateNxt = DROP;
            badInc   = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!rxDvIn) begin
          stateNxt = IDLE;
          badInc   = 1'b1;
        end else if (rxDataIn == 8'hD5) begin
          stateNxt = DATA;
          lenNxt   = '0;
          crcNxt   = CRC_INIT;
          erNxt    = 1'b0;
        end else if (rxDataIn != 8'h55) begin
          stateNxt = DROP;
          badInc   = 1'b1;
        end
      end
      DATA: begin
        if (rxDvIn) begin
          dlNxt  = {dl[3:0], rxDataIn};
          crcNxt = crcByte(crc, rxDataIn);
          if (lenCnt != '1) begin
            lenNxt = lenCnt + 11'd1;
          end
          if (rxErIn) begin
            erNxt = 1'b1;
          end
          if (lenCnt >= DLY) begin
            validNxt = 1'b1;
            dataNxt  = dl[4];
          end
          // Byte MAX_LEN+1: close the frame on the beat already due.
          if (lenCnt == MAX_L) begin
            lastNxt  = 1'b1;
            frameNxt = 1'b1;
            badInc   = 1'b1;
            stateNxt = DROP;
          end
        end else begin
          stateNxt = IDLE;
          if (lenCnt < DLY) begin
            badInc = 1'b1;
          end else begin
            validNxt = 1'b1;
            lastNxt  = 1'b1;
            dataNxt  = dl[4];
            fcsNxt   = (crc != CRC_RES);
            frameNxt = erSeen || (lenCnt < MIN_L);
            if (fcsNxt || frameNxt) begin
              badInc = 1'b1;
            end else begin
              goodInc = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!rxDvIn) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
    goodNxt = goodCntOut;
    if (goodInc && goodCntOut != 16'hFFFF) begin
      goodNxt = goodCntOut + 16'd1;
    end
    badNxt = badCntOut;
    if (badInc && badCntOut != 16'hFFFF) begin
      badNxt = badCntOut + 16'd1;
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state       <= IDLE;
      dl          <= '0;
      lenCnt      <= '0;
      crc         <= '0;
      erSeen      <= 1'b0;
      armed       <= 1'b0;
      dataOut     <= 8'h00;
      validOut    <= 1'b0;
      lastOut     <= 1'b0;
      fcsErrOut   <= 1'b0;
      frameErrOut <= 1'b0;
      goodCntOut  <= 16'd0;
      badCntOut   <= 16'd0;
    end else begin
      state       <= stateNxt;
      dl          <= dlNxt;
      lenCnt      <= lenNxt;
      crc         <= crcNxt;
      erSeen      <= erNxt;
      armed       <= armedNxt;
      dataOut     <= dataNxt;
      validOut    <= validNxt;
      lastOut     <= lastNxt;
      fcsErrOut   <= fcsNxt;
      frameErrOut <= frameNxt;
      goodCntOut  <= goodNxt;
      badCntOut   <= badNxt;
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: directed frames against a frame-level model of
// rx_frame_parser (expected beats, timing, flags and counters).
module tb_rx_frame_parser;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LAT     = 6;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic        rxDvIn = 1'b0;
  logic        rxErIn = 1'b0;
  logic [7:0]  rxDataIn = 8'h00;
  logic [7:0]  dataOut;
  logic        validOut;
  logic        lastOut;
  logic        fcsErrOut;
  logic        frameErrOut;
  logic [15:0] goodCntOut;
  logic [15:0] badCntOut;

  rx_frame_parser #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .rxDvIn(rxDvIn),
    .rxErIn(rxErIn),
    .rxDataIn(rxDataIn),
    .dataOut(dataOut),
    .validOut(validOut),
    .lastOut(lastOut),
    .fcsErrOut(fcsErrOut),
    .frameErrOut(frameErrOut),
    .goodCntOut(goodCntOut),
    .badCntOut(badCntOut)
  );

  always #4 clkIn = ~clkIn;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         fcs;
    bit         fcsKnown;
    bit         frm;
    int         due;
  } beat_t;

  beat_t       expQ[$];
  logic [7:0]  frm[$];
  logic [7:0]  raw[$];
  logic [15:0] expGood = 16'd0;
  logic [15:0] expBad  = 16'd0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          totalBeats = 0;
  logic [7:0]  lastData = 8'h00;

  always @(posedge clkIn) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] q[$],
                                        input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  always @(negedge clkIn) begin
    beat_t e;
    if (rstIn) begin
      chk("rstOutputs",
          {24'd0, dataOut} | {28'd0, validOut, lastOut,
                              fcsErrOut, frameErrOut},
          32'd0);
      chk("rstCounters", {goodCntOut, badCntOut}, 32'd0);
    end else begin
      if (lastOut && !validOut) begin
        chk("lastNoValid", 32'd1, 32'd0);
      end
      if (validOut) begin
        totalBeats++;
        lastData = dataOut;
        if (expQ.size() == 0) begin
          chk("unexpectedBeat", {24'd0, dataOut}, 32'hFFFFFFFF);
        end else begin
          e = expQ.pop_front();
          chk("beatData", {24'd0, dataOut}, {24'd0, e.d});
          chk("beatCycle", cyc, e.due);
          chk("beatLast", {31'd0, lastOut}, {31'd0, e.last});
          if (e.last) begin
            chk("frameErr", {31'd0, frameErrOut}, {31'd0, e.frm});
            if (e.fcsKnown) begin
              chk("fcsErr", {31'd0, fcsErrOut}, {31'd0, e.fcs});
            end
          end
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        e = expQ.pop_front();
        chk("missedBeat", 32'd0, {24'd0, e.d});
      end
    end
  end

  task automatic drive(input logic dv, input logic er,
                       input logic [7:0] d, input logic rst);
    @(posedge clkIn);
    #1;
    rxDvIn   = dv;
    rxErIn   = er;
    rxDataIn = d;
    rstIn    = rst;
  endtask

  task automatic buildFrame(input int n, input int start,
                            input bit corrupt);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(start + i));
    c = crc32(frm, n);
    for (int b = 0; b < 4; b++) frm.push_back(c[8*b +: 8]);
    if (corrupt) frm[n] = frm[n] ^ 8'h01;
  endtask

  // Sends preamble, SFD, frm[] and a one-cycle gap; the model predicts
  // every beat from the frame-level rules and schedules it LAT cycles
  // after the byte is presented.
  task automatic sendFrame(input int rstAt, input int erAt);
    int          len, nBeats;
    bit          fcsBad, frmBad, aborted;
    logic [31:0] fcsField;
    logic        rst;
    beat_t       e;
    len    = frm.size();
    nBeats = (len < 5) ? 0 : (len > MAX_LEN) ? MAX_LEN - 4 : len - 4;
    fcsBad = 1'b0;
    if (len >= 5) begin
      fcsField = {frm[len-1], frm[len-2], frm[len-3], frm[len-4]};
      fcsBad   = (fcsField != crc32(frm, len - 4));
    end
    frmBad  = (len > MAX_LEN) || (len < MIN_LEN) || (erAt >= 0);
    aborted = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) begin
      rst = (rstAt >= 0) && (i >= rstAt) && (i < rstAt + 3);
      drive(1'b1, 1'(i == erAt), frm[i], rst);
      if (i == rstAt) begin
        aborted = 1'b1;
        expQ.delete();
        expGood = 16'd0;
        expBad  = 16'd0;
      end
      if (!aborted && i < nBeats) begin
        e.d        = frm[i];
        e.last     = (i == nBeats - 1);
        e.fcs      = fcsBad;
        e.fcsKnown = (len <= MAX_LEN);
        e.frm      = frmBad;
        e.due      = cyc + LAT;
        expQ.push_back(e);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    if (!aborted) begin
      if (nBeats > 0 && !fcsBad && !frmBad) expGood = sat(expGood);
      else expBad = sat(expBad);
    end
  endtask

  task automatic sendRaw();
    foreach (raw[i]) drive(1'b1, 1'b0, raw[i], 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle(input string nm);
    repeat (10) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk({nm, ".good"}, {16'd0, goodCntOut}, {16'd0, expGood});
    chk({nm, ".bad"}, {16'd0, badCntOut}, {16'd0, expBad});
    chk({nm, ".pending"}, expQ.size(), 32'd0);
  endtask

  initial begin
    int b0;
    logic [7:0] ref9[$];
    #2 rstIn = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("resetGood", {16'd0, goodCntOut}, 32'd0);
    chk("resetValid", {31'd0, validOut}, 32'd0);

    ref9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
             8'h36, 8'h37, 8'h38, 8'h39};
    chk("modelCrcCheck", crc32(ref9, 9), 32'hCBF43926);

    b0 = totalBeats;
    buildFrame(60, 0, 1'b0);
    sendFrame(-1, -1);
    settle("good64");
    chk("good64.beats", totalBeats - b0, 32'd60);
    chk("good64.lastData", {24'd0, lastData}, 32'h3B);
    chk("good64.goodLit", {16'd0, goodCntOut}, 32'd1);

    b0 = totalBeats;
    buildFrame(60, 0, 1'b1);
    sendFrame(-1, -1);
    settle("badFcs");
    chk("badFcs.beats", totalBeats - b0, 32'd60);
    chk("badFcs.badLit", {16'd0, badCntOut}, 32'd1);
    chk("badFcs.goodLit", {16'd0, goodCntOut}, 32'd1);

    b0 = totalBeats;
    buildFrame(36, 8'h40, 1'b0);
    sendFrame(-1, -1);
    settle("runt40");
    chk("runt40.beats", totalBeats - b0, 32'd36);

    b0 = totalBeats;
    buildFrame(1596, 0, 1'b0);
    sendFrame(-1, -1);
    settle("over1600");
    chk("over1600.beats", totalBeats - b0, 32'd1514);
    chk("over1600.badLit", {16'd0, badCntOut}, 32'd3);

    b0 = totalBeats;
    raw = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h02};
    sendRaw();
    expBad = sat(expBad);
    buildFrame(60, 8'h10, 1'b0);
    sendFrame(-1, -1);
    settle("badPreamble");
    chk("badPreamble.beats", totalBeats - b0, 32'd60);

    buildFrame(60, 8'h20, 1'b0);
    sendFrame(-1, 10);
    settle("rxEr");

    frm = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(-1, -1);
    settle("runt4");

    raw = '{8'h55, 8'h55};
    sendRaw();
    expBad = sat(expBad);
    settle("preambleAbort");

    b0 = totalBeats;
    buildFrame(1, 8'h77, 1'b0);
    sendFrame(-1, -1);
    settle("len5");
    chk("len5.beats", totalBeats - b0, 32'd1);
    chk("len5.lastData", {24'd0, lastData}, 32'h77);

    buildFrame(59, 8'h33, 1'b0);
    sendFrame(-1, -1);
    settle("len63");

    b0 = totalBeats;
    buildFrame(1514, 8'h05, 1'b0);
    sendFrame(-1, -1);
    settle("max1518");
    chk("max1518.beats", totalBeats - b0, 32'd1514);

    buildFrame(60, 8'h80, 1'b0);
    sendFrame(-1, -1);
    buildFrame(70, 8'h90, 1'b0);
    sendFrame(-1, -1);
    settle("backToBack");

    raw = '{8'h12, 8'h55, 8'hD5, 8'h00};
    sendRaw();
    expBad = sat(expBad);
    settle("idleGarbage");

    buildFrame(60, 8'h00, 1'b0);
    sendFrame(19, -1);
    buildFrame(60, 8'h00, 1'b0);
    sendFrame(-1, -1);
    settle("resetMidFrame");
    chk("resetMidFrame.goodLit", {16'd0, goodCntOut}, 32'd1);
    chk("resetMidFrame.badLit", {16'd0, badCntOut}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
